// File: rtl/shift_sequencer.sv
// Command-driven sequencer for a bidirectional shift register. It loads a word,
// feeds q back for a fixed number of shifts, then hands the result back over a handshake.
`timescale 1ns/1ps
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic             sr_load_shift,
    output logic             sr_right_left,
    output logic [WIDTH-1:0] sr_data_in,
    input  logic [WIDTH-1:0] sr_q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic             dir_reg, dir_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic [WIDTH-1:0] word_reg, word_next;

    logic sel_word;
    logic sel_feedback;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            dir_reg       <= 1'b0;
            remaining_reg <= '0;
            word_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            dir_reg       <= dir_next;
            remaining_reg <= remaining_next;
            word_reg      <= word_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        dir_next       = dir_reg;
        remaining_next = remaining_reg;
        word_next      = word_reg;
        cmd_ready      = 1'b0;
        busy           = 1'b1;
        res_valid      = 1'b0;
        res_data       = '0;
        sr_load_shift  = 1'b0;
        sr_right_left  = 1'b0;
        sel_word       = 1'b0;
        sel_feedback   = 1'b0;

        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    word_next      = cmd_data;
                    dir_next       = cmd_dir;
                    remaining_next = cmd_count;
                    state_next     = LOAD;
                end
            end
            LOAD: begin
                sr_load_shift = 1'b1;
                sr_right_left = dir_reg;
                sel_word      = 1'b1;
                state_next    = (remaining_reg != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                sr_right_left  = dir_reg;
                sel_feedback   = 1'b1;
                remaining_next = remaining_reg - CNT_W'(1);
                if (remaining_reg == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Reloading q into itself keeps the result stable while the consumer stalls.
                res_valid     = 1'b1;
                res_data      = sr_q;
                sr_load_shift = 1'b1;
                sel_feedback  = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-bit data mux: captured word in LOAD, register feedback in SHIFT/DONE, zero otherwise.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_data_mux
            assign sr_data_in[gi] = (sel_word & word_reg[gi]) | (sel_feedback & sr_q[gi]);
        end
    endgenerate

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with a behavioural shift register attached.
`timescale 1ns/1ps
module tb_shift_sequencer;
    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             cmd_dir = 1'b0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_data;
    logic             busy;
    logic             sr_load_shift;
    logic             sr_right_left;
    logic [WIDTH-1:0] sr_data_in;
    logic [WIDTH-1:0] sr_q;
    logic             reset_n;

    int check_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .cmd_dir      (cmd_dir),
        .cmd_count    (cmd_count),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .busy         (busy),
        .sr_load_shift(sr_load_shift),
        .sr_right_left(sr_right_left),
        .sr_data_in   (sr_data_in),
        .sr_q         (sr_q)
    );

    // Attached shift_register_bidir behaviour, reset tied to ~reset as at integration.
    assign reset_n = ~reset;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)           sr_q <= '0;
        else if (sr_load_shift) sr_q <= sr_data_in;
        else if (sr_right_left) sr_q <= sr_data_in >> 1;
        else                    sr_q <= sr_data_in << 1;
    end

    // Reference: the word after n logical shifts with zero fill, by plain arithmetic.
    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] w, input logic d, input int n);
        int v;
        if (n >= WIDTH) v = 0;
        else if (d)     v = int'(w) / (1 << n);
        else            v = (int'(w) * (1 << n)) % (1 << WIDTH);
        return v[WIDTH-1:0];
    endfunction

    task automatic do_command(input logic [WIDTH-1:0] w, input logic d, input logic [CNT_W-1:0] c,
                              input int hold, input bit keep_valid, input string tag);
        logic [WIDTH-1:0] exp;
        logic [WIDTH-1:0] step_exp;
        int lat;
        exp = ref_shift(w, d, int'(c));
        cmd_data  = w;
        cmd_dir   = d;
        cmd_count = c;
        cmd_valid = 1'b1;
        res_ready = 1'b0;
        check_cnt++;
        if (cmd_ready !== 1'b1)
            $display("FAIL %s accept_ready: cmd_ready=%b required 1", tag, cmd_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        // Scramble fields after acceptance; they must be ignored.
        cmd_data  = WIDTH'($urandom);
        cmd_dir   = 1'($urandom);
        cmd_count = CNT_W'($urandom);
        cmd_valid = keep_valid;
        check_cnt++;
        if ({busy, cmd_ready, res_valid, sr_load_shift, sr_right_left, sr_data_in} !== {4'b1001, d, w})
            $display("FAIL %s load_cycle: busy/rdy/rv/ld/rl/din=%b%b%b%b%b/%h required 1001%b/%h",
                     tag, busy, cmd_ready, res_valid, sr_load_shift, sr_right_left, sr_data_in, d, w);
        else pass_cnt++;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!res_valid && lat < 40) begin
                step_exp = ref_shift(w, d, lat - 1);
                check_cnt++;
                if ({busy, cmd_ready, sr_load_shift, sr_right_left, sr_data_in} !== {3'b100, d, step_exp})
                    $display("FAIL %s shift_cycle%0d: busy/rdy/ld/rl/din=%b%b%b%b/%h required 100%b/%h",
                             tag, lat, busy, cmd_ready, sr_load_shift, sr_right_left, sr_data_in, d, step_exp);
                else pass_cnt++;
            end
        end while (!res_valid && lat < 40);
        check_cnt++;
        if (lat !== int'(c) + 1)
            $display("FAIL %s latency: edges_after_accept=%0d required %0d", tag, lat, int'(c) + 1);
        else pass_cnt++;
        check_cnt++;
        if ({res_valid, res_data, sr_load_shift, sr_data_in, cmd_ready} !== {1'b1, exp, 1'b1, exp, 1'b0})
            $display("FAIL %s done_cycle: rv/res/ld/din/rdy=%b/%h/%b/%h/%b required 1/%h/1/%h/0",
                     tag, res_valid, res_data, sr_load_shift, sr_data_in, cmd_ready, exp, exp);
        else pass_cnt++;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_cnt++;
            if ({res_valid, res_data, cmd_ready} !== {1'b1, exp, 1'b0})
                $display("FAIL %s done_hold%0d: rv/res/rdy=%b/%h/%b required 1/%h/0",
                         tag, i, res_valid, res_data, cmd_ready, exp);
            else pass_cnt++;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check_cnt++;
        if ({busy, cmd_ready, res_valid, sr_load_shift, sr_right_left, sr_data_in, res_data} !== {5'b01000, 8'h00})
            $display("FAIL %s back_to_idle: busy/rdy/rv/ld/rl=%b%b%b%b%b din/res=%h/%h required 01000 0/0",
                     tag, busy, cmd_ready, res_valid, sr_load_shift, sr_right_left, sr_data_in, res_data);
        else pass_cnt++;
        $display("txn %s: word=%b dir=%b count=%0d hold=%0d -> res=%b (expected %b) latency=%0d",
                 tag, w, d, c, hold, res_data, exp, lat);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_cnt++;
        if ({cmd_ready, busy, res_valid, sr_load_shift, sr_right_left, sr_data_in, res_data} !== {5'b10000, 8'h00})
            $display("FAIL reset_held: rdy/busy/rv/ld/rl=%b%b%b%b%b din/res=%h/%h required 10000 0/0",
                     cmd_ready, busy, res_valid, sr_load_shift, sr_right_left, sr_data_in, res_data);
        else pass_cnt++;
        reset = 1'b0;
        @(posedge clk); #1;
        check_cnt++;
        if ({cmd_ready, busy, res_valid, sr_load_shift, sr_right_left, sr_data_in, res_data} !== {5'b10000, 8'h00})
            $display("FAIL reset_released: rdy/busy/rv/ld/rl=%b%b%b%b%b din/res=%h/%h required 10000 0/0",
                     cmd_ready, busy, res_valid, sr_load_shift, sr_right_left, sr_data_in, res_data);
        else pass_cnt++;
        $display("txn reset: outputs idle after reset");
    endtask

    task automatic test_directed();
        do_command(4'b1011, 1'b1, 3'd1, 0, 1'b0, "right1");
        do_command(4'b1011, 1'b0, 3'd2, 0, 1'b0, "left2");
        do_command(4'b0110, 1'b0, 3'd0, 0, 1'b0, "count0");
        do_command(4'b1111, 1'b1, 3'd7, 0, 1'b0, "right7");
        do_command(4'b1111, 1'b0, 3'd4, 0, 1'b0, "left4");
    endtask

    task automatic test_hold_done();
        do_command(4'b1001, 1'b0, 3'd1, 3, 1'b1, "hold3");
        do_command(4'b1100, 1'b1, 3'd2, 0, 1'b0, "after_hold");
    endtask

    task automatic test_reset_mid();
        bit bad;
        cmd_data  = 4'b1110;
        cmd_dir   = 1'b1;
        cmd_count = 3'd5;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_cnt++;
        if ({cmd_ready, busy, res_valid, sr_load_shift, sr_right_left, sr_data_in, res_data} !== {5'b10000, 8'h00})
            $display("FAIL reset_mid_abort: rdy/busy/rv/ld/rl=%b%b%b%b%b din/res=%h/%h required 10000 0/0",
                     cmd_ready, busy, res_valid, sr_load_shift, sr_right_left, sr_data_in, res_data);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        check_cnt++;
        if (bad !== 1'b0)
            $display("FAIL reset_mid_quiet: spurious res_valid/busy after abort=%b required 0", bad);
        else pass_cnt++;
        $display("txn reset_mid: command aborted in second shift cycle");
        do_command(4'b0111, 1'b0, 3'd3, 1, 1'b0, "post_reset");
    endtask

    task automatic test_back_to_back();
        do_command(4'b0001, 1'b0, 3'd3, 0, 1'b0, "b2b_a");
        do_command(4'b1000, 1'b1, 3'd3, 0, 1'b0, "b2b_b");
        do_command(4'b0101, 1'b0, 3'd1, 0, 1'b0, "b2b_c");
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            do_command(WIDTH'($urandom), 1'($urandom), CNT_W'($urandom),
                       int'($urandom_range(0, 2)), 1'b0, $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_hold_done();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
